// File: rtl/param_table_streamer.sv
// param_table_streamer: streams entries of a packed banks x rows constant table over valid/ready,
// single-bank or all-bank scan, optional looping, with a running sum of accepted entries.
module param_table_streamer #(
  parameter int NUM_BANKS = 2,
  parameter int NUM_ROWS = 3,
  parameter int WIDTH = 4,
  parameter logic [NUM_BANKS-1:0][NUM_ROWS-1:0][WIDTH-1:0] TABLE = {NUM_BANKS{12'h6E5}},
  localparam int BW = NUM_BANKS > 1 ? $clog2(NUM_BANKS) : 1,
  localparam int RW = NUM_ROWS > 1 ? $clog2(NUM_ROWS) : 1,
  localparam int SW = WIDTH + 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic          mode,
  input  logic [BW-1:0] bank_sel,
  input  logic          loop,
  input  logic          abort,
  output logic [WIDTH-1:0] out_data,
  output logic [BW-1:0] out_bank,
  output logic [RW-1:0] out_row,
  output logic          out_valid,
  input  logic          out_ready,
  output logic          out_last,
  output logic          busy,
  output logic          done,
  output logic [SW-1:0] sum
);
  typedef enum logic {IDLE, STREAM} state_t;
  localparam logic [BW:0] NB = (BW+1)'(NUM_BANKS);
  localparam logic [BW-1:0] LAST_BANK = BW'(NUM_BANKS - 1);
  localparam logic [RW-1:0] LAST_ROW = RW'(NUM_ROWS - 1);
  state_t state, state_n;
  logic [BW-1:0] bank, bank_n;
  logic [RW-1:0] row, row_n;
  logic [SW-1:0] sum_n;
  logic mode_r, mode_n, loop_r, loop_n, done_n, row_end;
  assign busy = state == STREAM;
  assign out_valid = busy;
  assign out_bank = bank;
  assign out_row = row;
  assign out_data = TABLE[bank][row];
  assign row_end = row == LAST_ROW;
  // mode 0 ends each pass at the last row; mode 1 only at the last row of the last bank
  assign out_last = busy && row_end && (!mode_r || bank == LAST_BANK);
  always_comb begin
    state_n = state;
    bank_n = bank;
    row_n = row;
    sum_n = sum;
    mode_n = mode_r;
    loop_n = loop_r;
    done_n = 1'b0;
    if (state == IDLE) begin
      if (start && (mode || {1'b0, bank_sel} < NB)) begin
        state_n = STREAM;
        mode_n = mode;
        loop_n = loop;
        sum_n = '0;
        bank_n = mode ? '0 : bank_sel;
        row_n = '0;
      end
    end else if (abort) begin
      state_n = IDLE;
    end else if (out_ready) begin
      sum_n = sum + {16'd0, out_data};
      row_n = row_end ? '0 : row + 1'b1;
      bank_n = (row_end && mode_r) ? (bank == LAST_BANK ? '0 : bank + 1'b1) : bank;
      state_n = (out_last && !loop_r) ? IDLE : STREAM;
      done_n = out_last && !loop_r;
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      bank <= '0;
      row <= '0;
      sum <= '0;
      mode_r <= 1'b0;
      loop_r <= 1'b0;
      done <= 1'b0;
    end else begin
      state <= state_n;
      bank <= bank_n;
      row <= row_n;
      sum <= sum_n;
      mode_r <= mode_n;
      loop_r <= loop_n;
      done <= done_n;
    end
  end
endmodule

// File: tb/tb_param_table_streamer.sv
// tb_param_table_streamer: directed scans with scoreboard queues popped by per-DUT monitors.
module tb_param_table_streamer;
  typedef struct packed {logic [1:0] b; logic [1:0] r; logic [3:0] d; logic l;} ent_t;
  logic clk = 1'b0, rst_n = 1'b0;
  logic start = 1'b0, mode = 1'b0, loop = 1'b0, abort = 1'b0, out_ready = 1'b1;
  logic [0:0] bank_sel = '0;
  logic [3:0] out_data;
  logic [0:0] out_bank;
  logic [1:0] out_row;
  logic out_valid, out_last, busy, done;
  logic [19:0] sum;
  logic start2 = 1'b0;
  logic [1:0] bank_sel2 = '0;
  logic [3:0] data2;
  logic [1:0] bank2, row2;
  logic valid2, last2, busy2, done2;
  logic [19:0] sum2;
  int compared = 0, mismatched = 0;
  ent_t q[$], q2[$];
  ent_t held, cur, e;
  logic held_v = 1'b0;
  param_table_streamer dut (
    .clk(clk), .rst_n(rst_n), .start(start), .mode(mode), .bank_sel(bank_sel), .loop(loop),
    .abort(abort), .out_data(out_data), .out_bank(out_bank), .out_row(out_row),
    .out_valid(out_valid), .out_ready(out_ready), .out_last(out_last), .busy(busy),
    .done(done), .sum(sum)
  );
  param_table_streamer #(.NUM_BANKS(3), .NUM_ROWS(3), .WIDTH(4), .TABLE(36'h987CBA321)) dut2 (
    .clk(clk), .rst_n(rst_n), .start(start2), .mode(1'b0), .bank_sel(bank_sel2), .loop(1'b0),
    .abort(1'b0), .out_data(data2), .out_bank(bank2), .out_row(row2),
    .out_valid(valid2), .out_ready(1'b1), .out_last(last2), .busy(busy2),
    .done(done2), .sum(sum2)
  );
  always #5 clk = ~clk;
  initial begin
    #300000;
    $display("FAIL timeout: got no finish, required finish");
    $fatal(1, "timeout");
  end
  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h required %0h", name, act, exp);
    end
  endfunction
  always @(negedge clk) begin
    cur = {1'b0, out_bank, out_row, out_data, out_last};
    if (!rst_n) held_v = 1'b0;
    else begin
      if (held_v && out_valid) chk("stall_stable", 32'(cur), 32'(held));
      if (out_valid && out_ready) begin
        if (q.size() == 0) chk("unexpected_entry", 32'(cur), 32'h1FF);
        else begin
          e = q.pop_front();
          chk("entry", 32'(cur), 32'(e));
        end
      end
      held_v = out_valid && !out_ready;
      held = cur;
    end
  end
  always @(negedge clk) begin
    if (rst_n && valid2) begin
      if (q2.size() == 0) chk("unexpected_entry2", 32'({bank2, row2, data2, last2}), 32'h1FF);
      else chk("entry2", 32'({bank2, row2, data2, last2}), 32'(q2.pop_front()));
    end
  end
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic push(input logic [1:0] b, input logic [1:0] r, input logic [3:0] d, input logic l);
    q.push_back({b, r, d, l});
  endtask
  task automatic push_bank(input logic [1:0] b, input logic last_bank);
    push(b, 2'd0, 4'h5, 1'b0);
    push(b, 2'd1, 4'hE, 1'b0);
    push(b, 2'd2, 4'h6, last_bank);
  endtask
  task automatic launch(input logic m, input logic [0:0] bs, input logic lp);
    start = 1'b1;
    mode = m;
    bank_sel = bs;
    loop = lp;
    step();
    start = 1'b0;
    chk("busy_after_start", 32'(busy), 32'd1);
    chk("valid_after_start", 32'(out_valid), 32'd1);
  endtask
  task automatic finish_scan(input logic [19:0] exp_sum, input bit stall);
    int i = 0;
    while (!done && i < 200) begin
      out_ready = stall ? (i % 3 == 0) : 1'b1;
      step();
      i++;
    end
    chk("done_seen", 32'(done), 32'd1);
    chk("busy_at_done", 32'(busy), 32'd0);
    chk("sum", 32'(sum), 32'(exp_sum));
    out_ready = 1'b1;
    step();
    chk("done_one_cycle", 32'(done), 32'd0);
  endtask
  task automatic check_reset_vals();
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_last", 32'(out_last), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_sum", 32'(sum), 32'd0);
    chk("rst_bank_row", 32'({out_bank, out_row}), 32'd0);
    chk("rst_data", 32'(out_data), 32'h5);
  endtask
  initial begin
    #2;
    check_reset_vals();
    step();
    rst_n = 1'b1;
    step();
    // single bank, no stall
    push_bank(2'd0, 1'b1);
    launch(1'b0, 1'b0, 1'b0);
    finish_scan(20'd25, 1'b0);
    // all banks, no stall
    push_bank(2'd0, 1'b0);
    push_bank(2'd1, 1'b1);
    launch(1'b1, 1'b0, 1'b0);
    finish_scan(20'd50, 1'b0);
    // all banks with ready pattern 1,0,0,1,...
    push_bank(2'd0, 1'b0);
    push_bank(2'd1, 1'b1);
    launch(1'b1, 1'b0, 1'b0);
    finish_scan(20'd50, 1'b1);
    // looping single bank, seven transfers then abort
    push_bank(2'd0, 1'b1);
    push_bank(2'd0, 1'b1);
    push(2'd0, 2'd0, 4'h5, 1'b0);
    launch(1'b0, 1'b0, 1'b1);
    repeat (7) step();
    chk("loop_still_busy", 32'(busy), 32'd1);
    chk("loop_no_done", 32'(done), 32'd0);
    abort = 1'b1;
    out_ready = 1'b0;
    step();
    abort = 1'b0;
    out_ready = 1'b1;
    chk("abort_idle", 32'(busy), 32'd0);
    chk("abort_no_done", 32'(done), 32'd0);
    chk("abort_sum", 32'(sum), 32'd55);
    step();
    chk("abort_no_done_later", 32'(done), 32'd0);
    loop = 1'b0;
    // three-bank instance: bank 1, then an out-of-range bank
    q2.push_back({2'd1, 2'd0, 4'hA, 1'b0});
    q2.push_back({2'd1, 2'd1, 4'hB, 1'b0});
    q2.push_back({2'd1, 2'd2, 4'hC, 1'b1});
    start2 = 1'b1;
    bank_sel2 = 2'd1;
    step();
    start2 = 1'b0;
    chk("b1_busy", 32'(busy2), 32'd1);
    for (int i = 0; i < 20 && !done2; i++) step();
    chk("b1_done", 32'(done2), 32'd1);
    chk("b1_sum", 32'(sum2), 32'd33);
    chk("q2_empty", 32'(q2.size()), 32'd0);
    step();
    start2 = 1'b1;
    bank_sel2 = 2'd3;
    step();
    start2 = 1'b0;
    chk("b3_no_busy", 32'(busy2), 32'd0);
    chk("b3_no_valid", 32'(valid2), 32'd0);
    step();
    chk("b3_no_done", 32'(done2), 32'd0);
    chk("b3_still_idle", 32'(busy2), 32'd0);
    // reset after two transfers, then a fresh scan
    push(2'd0, 2'd0, 4'h5, 1'b0);
    push(2'd0, 2'd1, 4'hE, 1'b0);
    launch(1'b0, 1'b0, 1'b0);
    step();
    step();
    chk("pre_reset_sum", 32'(sum), 32'd19);
    #1;
    rst_n = 1'b0;
    #1;
    check_reset_vals();
    step();
    rst_n = 1'b1;
    step();
    chk("post_reset_no_done", 32'(done), 32'd0);
    push_bank(2'd0, 1'b1);
    launch(1'b0, 1'b0, 1'b0);
    chk("fresh_data", 32'(out_data), 32'h5);
    finish_scan(20'd25, 1'b0);
    chk("q_empty", 32'(q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
